// File: rtl/sipo_pkg.sv
// Shared definitions for the serial-in / parallel-out deserializer.
package sipo_pkg;

    // Word assembly state: idle means no bits of the current word captured yet.
    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } sipo_state_t;

endpackage

// File: rtl/sipo_bit_counter.sv
// Counts serial bits within a word; wraps to zero on the Nth bit.
module sipo_bit_counter #(
    parameter int N = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 inc,
    output logic [$clog2(N)-1:0] count,
    output logic                 wrap
);

    localparam int CW = $clog2(N);

    // Last bit of a word is being counted this cycle.
    always_comb begin
        wrap = inc && (count == CW'(N - 1));
    end

    // Bit position register: clear wins, then increment with wrap.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc) begin
            count <= wrap ? '0 : count + CW'(1);
        end
    end

endmodule

// File: rtl/sipo_deserializer.sv
// Serial-in / parallel-out deserializer with a one-word hold register,
// ready/valid output handshake and a sticky overrun flag.
module sipo_deserializer
    import sipo_pkg::*;
#(
    parameter int N         = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 sin,
    input  logic                 sin_valid,
    input  logic                 out_ready,
    output logic [N-1:0]         data_out,
    output logic                 out_valid,
    output logic                 load,
    output logic [$clog2(N)-1:0] bit_count,
    output logic                 overrun
);

    sipo_state_t state;
    sipo_state_t state_next;

    logic [N-1:0] shift_reg;
    logic [N-1:0] shift_next;
    logic         wrap;
    logic         word_done;
    logic         hold_free;

    sipo_bit_counter #(
        .N (N)
    ) u_bit_counter (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .inc   (sin_valid),
        .count (bit_count),
        .wrap  (wrap)
    );

    // Shift direction is fixed at elaboration: first bit ends up at the MSB or LSB.
    generate
        if (MSB_FIRST) begin : g_msb_first
            always_comb begin
                shift_next = {shift_reg[N-2:0], sin};
            end
        end else begin : g_lsb_first
            always_comb begin
                shift_next = {sin, shift_reg[N-1:1]};
            end
        end
    endgenerate

    // Handshake terms; load is only ever high while a word is actually held.
    always_comb begin
        word_done = sin_valid && wrap && !clear;
        hold_free = !out_valid || out_ready;
        load      = out_valid && out_ready;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state: tracks whether a partial word is in flight.
    // NOTE: state_next gets a default first so no path leaves it unassigned and infers a latch.
    always_comb begin
        state_next = state;
        if (clear) begin
            state_next = S_IDLE;
        end else if (sin_valid) begin
            case (state)
                S_IDLE:  state_next = wrap ? S_IDLE : S_SHIFT;
                S_SHIFT: state_next = wrap ? S_IDLE : S_SHIFT;
                default: state_next = S_IDLE;
            endcase
        end
    end

    // Shift register: captures one bit per valid cycle, holds otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_reg <= '0;
        end else if (clear) begin
            shift_reg <= '0;
        end else if (sin_valid) begin
            shift_reg <= shift_next;
        end
    end

    // Hold register and flags: accept a finished word when free, else flag overrun.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_out  <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else if (clear) begin
            data_out  <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else if (word_done && hold_free) begin
            data_out  <= shift_next;
            out_valid <= 1'b1;
        end else if (word_done) begin
            overrun   <= 1'b1;
        end else if (load) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed bench: two instances (MSB-first and LSB-first) share stimulus.
module tb_sipo_deserializer;

    localparam int N = 8;

    logic         clk;
    logic         rst;
    logic         clear;
    logic         sin;
    logic         sin_valid;
    logic         out_ready;

    logic [N-1:0] data_msb, data_lsb;
    logic         valid_msb, valid_lsb;
    logic         load_msb, load_lsb;
    logic [2:0]   count_msb, count_lsb;
    logic         ovr_msb, ovr_lsb;

    int checks = 0;
    int errors = 0;

    sipo_deserializer #(.N(N), .MSB_FIRST(1'b1)) dut_msb (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .sin       (sin),
        .sin_valid (sin_valid),
        .out_ready (out_ready),
        .data_out  (data_msb),
        .out_valid (valid_msb),
        .load      (load_msb),
        .bit_count (count_msb),
        .overrun   (ovr_msb)
    );

    sipo_deserializer #(.N(N), .MSB_FIRST(1'b0)) dut_lsb (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .sin       (sin),
        .sin_valid (sin_valid),
        .out_ready (out_ready),
        .data_out  (data_lsb),
        .out_valid (valid_lsb),
        .load      (load_lsb),
        .bit_count (count_lsb),
        .overrun   (ovr_lsb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        sin       = b;
        sin_valid = 1'b1;
        cycle();
        sin_valid = 1'b0;
    endtask

    // Sends w[7] first, down to w[0].
    task automatic send_word(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) begin
            send_bit(w[i]);
        end
    endtask

    initial begin
        rst       = 1'b0;
        clear     = 1'b0;
        sin       = 1'b0;
        sin_valid = 1'b0;
        out_ready = 1'b0;

        // Reset state
        cycle();
        cycle();
        check("rst_data",    32'(data_msb),  32'h00);
        check("rst_valid",   32'(valid_msb), 32'h0);
        check("rst_count",   32'(count_msb), 32'h0);
        check("rst_overrun", 32'(ovr_msb),   32'h0);
        out_ready = 1'b1;
        #1;
        check("rst_load", 32'(load_msb), 32'h0);
        out_ready = 1'b0;
        rst = 1'b1;
        cycle();

        // Bits 1,0,1,1,0,1,0,0: 8'hB4 MSB-first, 8'h2D LSB-first, 1-cycle latency
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        check("b7_count", 32'(count_msb), 32'd7);
        check("b7_valid", 32'(valid_msb), 32'h0);
        send_bit(1'b0);
        check("w1_valid_msb", 32'(valid_msb), 32'h1);
        check("w1_data_msb",  32'(data_msb),  32'hB4);
        check("w1_valid_lsb", 32'(valid_lsb), 32'h1);
        check("w1_data_lsb",  32'(data_lsb),  32'h2D);
        check("w1_count",     32'(count_msb), 32'h0);

        // Word pending, out_ready low, next word 8'h2D completes -> dropped, overrun
        send_word(8'h2D);
        check("ovr_data",  32'(data_msb),  32'hB4);
        check("ovr_valid", 32'(valid_msb), 32'h1);
        check("ovr_flag",  32'(ovr_msb),   32'h1);
        check("ovr_flag_lsb", 32'(ovr_lsb), 32'h1);
        out_ready = 1'b1;
        #1;
        check("ovr_load_hi", 32'(load_msb), 32'h1);
        cycle();
        check("ovr_valid_clr", 32'(valid_msb), 32'h0);
        check("ovr_load_lo",   32'(load_msb),  32'h0);
        check("ovr_sticky",    32'(ovr_msb),   32'h1);
        out_ready = 1'b0;

        // Clear flushes the sticky overrun flag
        clear = 1'b1;
        cycle();
        clear = 1'b0;
        check("clr_overrun", 32'(ovr_msb), 32'h0);

        // out_ready together with next word completion: load and replace
        send_word(8'hB4);
        check("bb_first", 32'(data_msb), 32'hB4);
        for (int i = 7; i >= 1; i--) begin
            send_bit(1'(8'h2D >> i));
        end
        out_ready = 1'b1;
        sin       = 1'b1;
        sin_valid = 1'b1;
        #1;
        check("bb_load", 32'(load_msb), 32'h1);
        cycle();
        sin_valid = 1'b0;
        check("bb_data",    32'(data_msb),  32'h2D);
        check("bb_valid",   32'(valid_msb), 32'h1);
        check("bb_overrun", 32'(ovr_msb),   32'h0);
        cycle();
        check("bb_drain", 32'(valid_msb), 32'h0);
        out_ready = 1'b0;

        // Clear mid-word with sin_valid: bit not captured, next word clean
        for (int i = 0; i < 5; i++) begin
            send_bit(1'b1);
        end
        check("clr_pre_count", 32'(count_msb), 32'd5);
        clear     = 1'b1;
        sin       = 1'b1;
        sin_valid = 1'b1;
        cycle();
        clear     = 1'b0;
        sin_valid = 1'b0;
        check("clr_count", 32'(count_msb), 32'h0);
        check("clr_valid", 32'(valid_msb), 32'h0);
        send_word(8'hB4);
        check("clr_word_msb", 32'(data_msb), 32'hB4);
        check("clr_word_lsb", 32'(data_lsb), 32'h2D);

        // Reset mid-word with a word pending; idle cycles hold the count
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
        check("rst_pre_count", 32'(count_msb), 32'd3);
        cycle();
        cycle();
        check("hold_count", 32'(count_msb), 32'd3);
        rst = 1'b0;
        #1;
        check("arst_data",  32'(data_msb),  32'h00);
        check("arst_valid", 32'(valid_msb), 32'h0);
        check("arst_count", 32'(count_msb), 32'h0);
        cycle();
        rst = 1'b1;
        cycle();
        // 0,1,1,0,0,0,1,1 -> 8'h63 MSB-first, 8'hC6 LSB-first
        send_word(8'h63);
        check("post_rst_msb",   32'(data_msb),  32'h63);
        check("post_rst_lsb",   32'(data_lsb),  32'hC6);
        check("post_rst_valid", 32'(valid_msb), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sipo_deserializer.md
SIPO_DESERIALIZER -- requirements
Module: sipo_deserializer

Interface
REQ-001 SHALL have parameter N, default 8, meaning word width in bits (legal N >= 2).
REQ-002 SHALL have parameter MSB_FIRST, default 1, meaning 1 = first serial bit lands in data_out[N-1] and 0 = first bit lands in data_out[0].
REQ-003 SHALL have port clk, input, 1 bit, meaning rising-edge clock.
REQ-004 SHALL have port rst, input, 1 bit, meaning asynchronous active-low reset.
REQ-005 SHALL have port clear, input, 1 bit, meaning synchronous flush of all state.
REQ-006 SHALL have port sin, input, 1 bit, meaning serial data bit.
REQ-007 SHALL have port sin_valid, input, 1 bit, meaning sin is sampled this cycle.
REQ-008 SHALL have port out_ready, input, 1 bit, meaning the downstream register accepts the word this cycle.
REQ-009 SHALL have port data_out, output, N bits, meaning assembled word from the hold register.
REQ-010 SHALL have port out_valid, output, 1 bit, meaning data_out holds an unconsumed word.
REQ-011 SHALL have port load, output, 1 bit, meaning out_valid & out_ready, used directly as the downstream register's load strobe.
REQ-012 SHALL have port bit_count, output, $clog2(N) bits, meaning the number of bits currently in the partial word.
REQ-013 SHALL have port overrun, output, 1 bit, meaning a sticky flag set when a completed word was dropped.

Function
REQ-014 SHALL use a two-state FSM: S_IDLE (bit_count = 0) and S_SHIFT (0 < bit_count < N).
REQ-015 SHALL, on each cycle with sin_valid = 1, shift sin into the shift register per MSB_FIRST and increment bit_count.
REQ-016 SHALL, on a cycle with sin_valid = 1 and bit_count = N-1, complete the word: bit_count wraps to 0 and the FSM returns to S_IDLE.
REQ-017 SHALL, on a completed word while the hold register is free, write it to data_out and assert out_valid on the next cycle (1-cycle latency from the Nth bit). Free means out_valid = 0, or out_valid = 1 with out_ready = 1 in the same cycle.
REQ-018 SHALL, on a completed word while out_valid = 1 and out_ready = 0, drop the new word, keep data_out unchanged and set overrun.
REQ-019 SHALL, when out_ready = 1 with out_valid = 1 and no word completing, clear out_valid on the next cycle.
REQ-020 SHALL ignore out_ready while out_valid = 0; load = 0 in that case.
REQ-021 SHALL continue shifting while a word is pending (double-buffered); a pending word never stalls serial input.
REQ-022 SHALL hold the shift register, bit_count and FSM state on cycles with sin_valid = 0.
REQ-023 SHALL, when clear = 1, take priority over all other inputs: next cycle bit_count = 0, S_IDLE, out_valid = 0, overrun = 0, and the partial word is discarded.
REQ-024 SHALL clear overrun only by clear or rst.
REQ-025 SHALL keep data_out stable whenever out_valid = 1 and no new word is accepted.

Reset
REQ-026 SHALL, while rst = 0, immediately force data_out = 0, shift register = 0, bit_count = 0, out_valid = 0, overrun = 0, FSM = S_IDLE.
REQ-027 SHALL discard any partial or pending word when rst asserts mid-operation; the first bit after release starts a new word.
REQ-028 SHALL drive load = 0 during reset.

Structure
REQ-029 SHALL define the FSM state typedef (S_IDLE, S_SHIFT) in shared package sipo_pkg.
REQ-030 SHALL implement the bit counter as sub-module sipo_bit_counter, with parameter N, ports clk, rst, clear and inc, outputs count and wrap.
REQ-031 SHALL contain no latches and use a single clock domain.

Verification (N=8)
REQ-032 SHALL verify: MSB_FIRST=1, bits 1,0,1,1,0,1,0,0 on consecutive cycles -> data_out = 8'hB4, out_valid high the cycle after bit 8.
REQ-033 SHALL verify: MSB_FIRST=0, same bits -> data_out = 8'h2D.
REQ-034 SHALL verify: word 8'hB4 pending with out_ready = 0, then 8 more bits completing 8'h2D -> data_out stays 8'hB4, overrun = 1; then out_ready = 1 -> load pulses once and out_valid clears.
REQ-035 SHALL verify: out_ready = 1 in the same cycle as the next word completes -> load = 1, data_out becomes the new word, out_valid stays 1, overrun stays 0.
REQ-036 SHALL verify: after 5 bits (bit_count = 5), clear = 1 together with sin_valid = 1 -> bit_count = 0, the bit is not captured, and the next 8 bits form a clean word.
REQ-037 SHALL verify: rst pulled low at bit_count = 3 with a word pending -> all outputs 0 immediately, and a full 8-bit sequence after release yields the correct word.
